// File: rtl/mvau_inp_buffer.sv
// Input activation buffer for mvau_stream: captures one SF-word vector and replays it NF times.
// Define MVAU_INP_BUF_PINGPONG_EN for two banks; the default build uses a single bank.
module mvau_inp_buffer #(
  parameter int SIMD    = 2,
  parameter int TSrcI   = 4,
  parameter int MatrixW = 8,
  parameter int MatrixH = 4,
  parameter int PE      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_v,
  output logic                  in_rdy,
  input  logic [SIMD*TSrcI-1:0] in_act,
  output logic                  out_v,
  input  logic                  out_rdy,
  output logic [SIMD*TSrcI-1:0] out_act,
  output logic                  out_first,
  output logic                  out_last
);

  localparam int DW  = SIMD * TSrcI;
  localparam int SF  = MatrixW / SIMD;
  localparam int NF  = MatrixH / PE;
  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
`ifdef MVAU_INP_BUF_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [SFW-1:0] SF_LAST = SFW'(SF - 1);
  localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);

  logic [DW-1:0]  mem_q [NB][SF];
  logic [NB-1:0]  full_q, full_d;
  logic           wrBank_q, wrBank_d;
  logic [SFW-1:0] wrAddr_q, wrAddr_d;
  logic           rdBank_q, rdBank_d;
  logic [SFW-1:0] rdSf_q, rdSf_d;
  logic [NFW-1:0] rdNf_q, rdNf_d;
  logic           outV_q, outV_d;
  logic [DW-1:0]  outAct_q, outAct_d;
  logic           outFirst_q, outFirst_d;
  logic           outLast_q, outLast_d;

  logic wrFire, wrDone, load, rdDone;

  assign in_rdy    = !full_q[wrBank_q];
  assign wrFire    = in_v && in_rdy;
  assign wrDone    = wrFire && (wrAddr_q == SF_LAST);
  assign load      = full_q[rdBank_q] && (!outV_q || out_rdy);
  assign rdDone    = load && (rdSf_q == SF_LAST) && (rdNf_q == NF_LAST);

  assign out_v     = outV_q;
  assign out_act   = outAct_q;
  assign out_first = outFirst_q;
  assign out_last  = outLast_q;

  // Set and clear of the full flags never hit the same bank, so both apply in one cycle.
  always_comb begin
    full_d     = full_q;
    wrAddr_d   = wrAddr_q;
    wrBank_d   = (NB == 2) ? (wrBank_q ^ wrDone) : 1'b0;
    rdBank_d   = (NB == 2) ? (rdBank_q ^ rdDone) : 1'b0;
    rdSf_d     = rdSf_q;
    rdNf_d     = rdNf_q;
    outV_d     = outV_q;
    outAct_d   = outAct_q;
    outFirst_d = outFirst_q;
    outLast_d  = outLast_q;

    if (wrFire) begin
      wrAddr_d = wrDone ? '0 : wrAddr_q + SFW'(1);
    end
    if (wrDone) begin
      full_d[wrBank_q] = 1'b1;
    end

    if (load) begin
      outV_d     = 1'b1;
      outAct_d   = mem_q[rdBank_q][rdSf_q];
      outFirst_d = (rdSf_q == '0);
      outLast_d  = (rdSf_q == SF_LAST);
      if (rdSf_q == SF_LAST) begin
        rdSf_d = '0;
        rdNf_d = (rdNf_q == NF_LAST) ? '0 : rdNf_q + NFW'(1);
      end else begin
        rdSf_d = rdSf_q + SFW'(1);
      end
    end else if (out_rdy) begin
      outV_d = 1'b0;
    end

    if (rdDone) begin
      full_d[rdBank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      wrAddr_q   <= '0;
      rdBank_q   <= 1'b0;
      rdSf_q     <= '0;
      rdNf_q     <= '0;
      outV_q     <= 1'b0;
      outAct_q   <= '0;
      outFirst_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      wrAddr_q   <= wrAddr_d;
      rdBank_q   <= rdBank_d;
      rdSf_q     <= rdSf_d;
      rdNf_q     <= rdNf_d;
      outV_q     <= outV_d;
      outAct_q   <= outAct_d;
      outFirst_q <= outFirst_d;
      outLast_q  <= outLast_d;
    end
  end

  // Vector storage needs no reset: the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (wrFire) begin
      mem_q[wrBank_q][wrAddr_q] <= in_act;
    end
  end

endmodule

// File: doc/mvau_inp_buffer.md
# mvau_inp_buffer

Input activation buffer placed directly upstream of `mvau_stream`. It accepts one input activation vector as MatrixW/SIMD words of SIMD lanes. It then replays that vector MatrixH/PE times, once per PE fold, so the stream unit can compute every output row against the same input column. Two banks let the next vector be written while the current one is replayed, which keeps the MVAU datapath busy without bubbles.

## Interface
- `SIMD`, 2, input lanes per word.
- `TSrcI`, 4, bits per input activation lane.
- `MatrixW`, 8, vector length in elements; must be divisible by SIMD. SF = MatrixW/SIMD.
- `MatrixH`, 4, output rows; must be divisible by PE. NF = MatrixH/PE.
- `PE`, 2, processing elements in the downstream MVAU.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_v`  in  1  input word valid.
- `in_rdy`  out  1  buffer can accept a word.
- `in_act`  in  SIMD*TSrcI  input word, lane 0 in MSBs.
- `out_v`  out  1  output word valid.
- `out_rdy`  in  1  downstream accepts output word.
- `out_act`  out  SIMD*TSrcI  replayed word to `mvau_stream` `in_act`.
- `out_first`  out  1  word is index 0 of a fold; this is the accumulator-clear cue.
- `out_last`  out  1  word is index SF-1 of a fold.

## Operation
- Storage: 2 banks × SF words. Each bank has a `full` flag.
- Write side
  - `wr_bank` (1 bit) and `wr_addr` (0..SF-1) select the write location.
  - `in_rdy = !full[wr_bank]`, combinational from registered state.
  - On `in_v & in_rdy`, the word is written and `wr_addr` increments.
  - At `wr_addr == SF-1`: `wr_addr` wraps to 0, `full[wr_bank]` is set, and `wr_bank` toggles.
- Read side
  - Counters: `rd_bank`, `rd_sf` (0..SF-1) and `rd_nf` (0..NF-1).
  - Load condition: `full[rd_bank] & (!out_v | out_rdy)`.
  - On load, these registers update from the current read position: `out_act = mem[rd_bank][rd_sf]`, `out_first = (rd_sf==0)`, `out_last = (rd_sf==SF-1)`, and `out_v = 1`.
  - After the load, `rd_sf` increments. On wrap, `rd_nf` increments.
  - When `rd_sf==SF-1` and `rd_nf==NF-1`, both counters wrap to 0, `full[rd_bank]` clears, and `rd_bank` toggles.
- Drain: if `out_v & out_rdy` and the load condition is false, `out_v` falls to 0.
- Output order per vector: words 0..SF-1, repeated NF times, for SF*NF beats in total.
- Same-cycle events:
  - Set and clear of `full` always target different banks, so both take effect.
  - Write completion and read release in one cycle are both honoured.
- Degenerate sizes:
  - SF=1: every accepted word is a complete vector, and `out_first = out_last = 1` on every beat.
  - NF=1: each vector is played once.
- Widths: counters are `$clog2(SF)` and `$clog2(NF)` bits, with a minimum of 1 bit. Data is never modified.

## Timing
- Reset values:
  - `out_v=0`, `out_act=0`, `out_first=0`, `out_last=0`.
  - All `full` flags 0, all pointers and counters 0.
  - `in_rdy=1` while reset is deasserted after reset.
- Reset is asynchronous. Asserting `rst` mid-operation clears state immediately and discards all buffered data. The next accepted word is word 0 of a new vector.
- Latency: the last word of a vector is accepted at edge E, so `full` is high after E. The first replay word has `out_v=1` after edge E+1, i.e. 2 edges after that input handshake.
- Handshake:
  - Once `out_v` is high, `out_act`, `out_first` and `out_last` are held stable until `out_rdy` is sampled high.
  - `in_rdy` may fall only at a bank-full edge.
- Throughput:
  - With continuous `out_rdy`, output delivers 1 word/cycle across vector boundaries, with no bubble, whenever the next bank is already full.
  - Input needs SF cycles per vector versus SF*NF cycles for replay.

## Configuration
- `MVAU_INP_BUF_PINGPONG_EN`
  - Defined: two banks as described above.
  - Undefined: a single bank. `wr_bank` and `rd_bank` are tied to 0, and `in_rdy` stays low from vector completion until the edge accepting the final replay beat (SF*NF-th). Storage halves.

## Test plan
- Basic replay (SIMD=2, TSrcI=4, SF=4, NF=2, `out_rdy=1`):
  - Stimulus: write 0x11, 0x22, 0x33, 0x44.
  - Required: out sequence 11,22,33,44,11,22,33,44.
  - `out_first` high on both 0x11 beats and `out_last` high on both 0x44 beats.
  - `out_v` rises 2 edges after the 0x44 handshake.
- Backpressure:
  - Stimulus: hold `out_rdy=0` for 3 cycles while 0x22 is presented.
  - Required: 0x22 held stable, no duplicated or dropped beats, total of 8 beats.
- Ping-pong (macro defined): two vectors back-to-back.
  - Required: `in_rdy` high for all 8 input words.
  - Output is 16 contiguous beats with no `out_v` gap at the vector boundary.
- Single-bank build (macro undefined):
  - Required: `in_rdy` goes 0 after the 4th word and returns to 1 on the edge accepting the 8th replay beat.
- Reset mid-replay:
  - Stimulus: assert `rst` while the 3rd output beat is valid.
  - Required: `out_v` goes 0 without waiting for a clock edge and `in_rdy` is 1 after release.
  - A new vector 0xA1..0xA4 replays starting at 0xA1.
- SF=1, NF=3:
  - Stimulus: words 0x5, 0x6.
  - Required: out 5,5,5,6,6,6 with `out_first = out_last = 1` on every beat.
